fetch_bp_bco_update: RTL and testbench

- Branch-predictor table that closes the loop with the BRU execute stage.
- Receives branch-commit-override (bco) reports and updates a direct-mapped BTB/pattern table.
- Serves the per-fetch predictions (bp_pattern/bp_taken/bp_hit/bp_target) that travel down the pipe into the BRU.
- Update reports are buffered in a small FIFO; drains are arbitrated against lookups to model a single-port table.

---
 rtl/fetch_bp_bco_update_if.sv | 36 +++
 rtl/fetch_bp_bco_update.sv | 140 ++++++++++++++
 tb/tb_fetch_bp_bco_update.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_bp_bco_update_if.sv
// Fetch-lookup / BRU-bco bundle for the branch-predictor table.
// master = fetch + BRU side, slave = predictor table.
interface fetch_bp_bco_update_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

    logic            i_lookup_valid;
    logic [31:0]     i_lookup_pc;
    logic            o_lookup_ready;
    logic            o_bp_valid;
    logic [1:0]      o_bp_pattern;
    logic            o_bp_taken;
    logic            o_bp_hit;
    logic [31:0]     o_bp_target;
    logic            i_bco_valid;
    logic [31:0]     i_bco_pc;
    logic [1:0]      i_bco_oldpattern;
    logic            i_bco_taken;
    logic [31:0]     i_bco_target;
    logic [CNTW-1:0] o_fifo_count;

    modport master (
        output i_lookup_valid, i_lookup_pc,
        output i_bco_valid, i_bco_pc, i_bco_oldpattern, i_bco_taken, i_bco_target,
        input  o_lookup_ready, o_bp_valid, o_bp_pattern, o_bp_taken, o_bp_hit,
        input  o_bp_target, o_fifo_count
    );

    modport slave (
        input  i_lookup_valid, i_lookup_pc,
        input  i_bco_valid, i_bco_pc, i_bco_oldpattern, i_bco_taken, i_bco_target,
        output o_lookup_ready, o_bp_valid, o_bp_pattern, o_bp_taken, o_bp_hit,
        output o_bp_target, o_fifo_count
    );
endinterface

// File: rtl/fetch_bp_bco_update.sv
// Direct-mapped BTB / 2-bit pattern table: serves fetch lookups and absorbs
// BRU bco reports through a small FIFO drained only in lookup-free cycles.
module fetch_bp_bco_update #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    fetch_bp_bco_update_if.slave bus
);
    localparam int unsigned IDXW = $clog2(ENTRIES);
    localparam int unsigned TAGW = 32 - IDXW - 2;
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  oldpattern;
        logic        taken;
        logic [31:0] target;
    } bco_t;

    bco_t            fifo_q [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;

    logic [ENTRIES-1:0] tbl_valid;
    logic [TAGW-1:0]    tbl_tag     [ENTRIES];
    logic [1:0]         tbl_pattern [ENTRIES];
    logic [31:0]        tbl_target  [ENTRIES];

    logic            lookup_acc;
    logic            push;
    logic            drain;
    bco_t            head;
    logic [IDXW-1:0] lk_idx;
    logic [TAGW-1:0] lk_tag;
    logic            lk_hit;
    logic [IDXW-1:0] dr_idx;
    logic [TAGW-1:0] dr_tag;
    logic            dr_hit;
    logic [1:0]      dr_pattern;
    logic [31:0]     dr_target;
    logic            unused_pc_bits;

    assign bus.o_lookup_ready = (count != CNTW'(FIFO_DEPTH));
    assign bus.o_fifo_count   = count;
    assign lookup_acc         = bus.i_lookup_valid & bus.o_lookup_ready;
    assign push               = bus.i_bco_valid;
    // Full implies not ready, so a drain always frees the slot a full-cycle push lands in.
    assign drain              = (count != '0) & ~lookup_acc;

    assign head           = fifo_q[rd_ptr];
    assign unused_pc_bits = ^{bus.i_lookup_pc[1:0], head.pc[1:0]};

    always_comb begin
        lk_idx = bus.i_lookup_pc[IDXW+1:2];
        lk_tag = bus.i_lookup_pc[31:IDXW+2];
        lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

        dr_idx = head.pc[IDXW+1:2];
        dr_tag = head.pc[31:IDXW+2];
        dr_hit = tbl_valid[dr_idx] && (tbl_tag[dr_idx] == dr_tag);

        dr_pattern = head.oldpattern;
        if (head.taken) begin
            if (head.oldpattern != 2'b11) dr_pattern = head.oldpattern + 2'b01;
        end else begin
            if (head.oldpattern != 2'b00) dr_pattern = head.oldpattern - 2'b01;
        end

        dr_target = (head.taken || !dr_hit) ? head.target : tbl_target[dr_idx];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{pc:         bus.i_bco_pc,
                                oldpattern: bus.i_bco_oldpattern,
                                taken:      bus.i_bco_taken,
                                target:     bus.i_bco_target};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + PTRW'(1);
            if (drain) rd_ptr <= rd_ptr + PTRW'(1);
            case ({push, drain})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tbl_valid <= '0;
        end else if (drain) begin
            tbl_valid[dr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (drain) begin
            tbl_tag[dr_idx]     <= dr_tag;
            tbl_pattern[dr_idx] <= dr_pattern;
            tbl_target[dr_idx]  <= dr_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.o_bp_valid   <= 1'b0;
            bus.o_bp_pattern <= '0;
            bus.o_bp_taken   <= 1'b0;
            bus.o_bp_hit     <= 1'b0;
            bus.o_bp_target  <= '0;
        end else begin
            bus.o_bp_valid <= lookup_acc;
            if (lookup_acc) begin
                bus.o_bp_hit <= lk_hit;
                if (lk_hit) begin
                    bus.o_bp_pattern <= tbl_pattern[lk_idx];
                    bus.o_bp_taken   <= tbl_pattern[lk_idx][1];
                    bus.o_bp_target  <= tbl_target[lk_idx];
                end else begin
                    bus.o_bp_pattern <= 2'b01;
                    bus.o_bp_taken   <= 1'b0;
                    bus.o_bp_target  <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_bp_bco_update.sv
// Scoreboard bench for fetch_bp_bco_update: a reference table model predicts
// each accepted lookup's response; the monitor pops and compares on o_bp_valid.
module tb_fetch_bp_bco_update;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    fetch_bp_bco_update_if #(.FIFO_DEPTH(4)) bus ();

    fetch_bp_bco_update #(.ENTRIES(16), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [1:0]  pattern;
        logic        taken;
        logic        hit;
        logic [31:0] target;
    } pred_t;

    pred_t       sb [$];
    pred_t       mon_exp;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic        m_valid [16];
    logic [25:0] m_tag   [16];
    logic [1:0]  m_pat   [16];
    logic [31:0] m_tgt   [16];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    function automatic pred_t model_lookup(input logic [31:0] pc);
        pred_t       p;
        int unsigned i;
        i = int'(pc[5:2]);
        if (m_valid[i] && m_tag[i] == pc[31:6]) begin
            p.pattern = m_pat[i];
            p.taken   = m_pat[i][1];
            p.hit     = 1'b1;
            p.target  = m_tgt[i];
        end else begin
            p.pattern = 2'b01;
            p.taken   = 1'b0;
            p.hit     = 1'b0;
            p.target  = 32'h0;
        end
        return p;
    endfunction

    task automatic model_update(input logic [31:0] pc, input logic [1:0] old,
                                input logic tkn, input logic [31:0] tgt);
        int unsigned i;
        logic        hit;
        i   = int'(pc[5:2]);
        hit = m_valid[i] && (m_tag[i] == pc[31:6]);
        case ({old, tkn})
            3'b00_0: m_pat[i] = 2'b00;
            3'b00_1: m_pat[i] = 2'b01;
            3'b01_0: m_pat[i] = 2'b00;
            3'b01_1: m_pat[i] = 2'b10;
            3'b10_0: m_pat[i] = 2'b01;
            3'b10_1: m_pat[i] = 2'b11;
            3'b11_0: m_pat[i] = 2'b10;
            default: m_pat[i] = 2'b11;
        endcase
        if (tkn || !hit) m_tgt[i] = tgt;
        m_valid[i] = 1'b1;
        m_tag[i]   = pc[31:6];
    endtask

    // Drive one cycle's inputs just after posedge; record expectations at negedge.
    task automatic drive(input logic lv, input logic [31:0] lpc,
                         input logic bv, input logic [31:0] bpc, input logic [1:0] bold,
                         input logic bt, input logic [31:0] btgt);
        @(posedge clk);
        #1;
        bus.i_lookup_valid   = lv;
        bus.i_lookup_pc      = lpc;
        bus.i_bco_valid      = bv;
        bus.i_bco_pc         = bpc;
        bus.i_bco_oldpattern = bold;
        bus.i_bco_taken      = bt;
        bus.i_bco_target     = btgt;
        @(negedge clk);
        if (lv && bus.o_lookup_ready) sb.push_back(model_lookup(lpc));
        if (bv) model_update(bpc, bold, bt, btgt);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    task automatic lookup(input logic [31:0] pc);
        drive(1'b1, pc, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
    endtask

    task automatic bco(input logic [31:0] pc, input logic [1:0] old, input logic tkn,
                       input logic [31:0] tgt);
        drive(1'b0, 32'h0, 1'b1, pc, old, tkn, tgt);
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.o_bp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk_eq("sb_underflow", sb.size(), 1);
            end else begin
                mon_exp = sb.pop_front();
                chk_eq("bp_pattern", bus.o_bp_pattern, mon_exp.pattern);
                chk_eq("bp_taken",   bus.o_bp_taken,   mon_exp.taken);
                chk_eq("bp_hit",     bus.o_bp_hit,     mon_exp.hit);
                chk_eq("bp_target",  bus.o_bp_target,  mon_exp.target);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

    task automatic chk_outputs_clear(input string tag);
        chk_eq({tag, "_valid"},   bus.o_bp_valid,   0);
        chk_eq({tag, "_pattern"}, bus.o_bp_pattern, 0);
        chk_eq({tag, "_taken"},   bus.o_bp_taken,   0);
        chk_eq({tag, "_hit"},     bus.o_bp_hit,     0);
        chk_eq({tag, "_target"},  bus.o_bp_target,  0);
        chk_eq({tag, "_count"},   bus.o_fifo_count, 0);
    endtask

    int unsigned exp_cnt [7] = '{0, 1, 2, 3, 4, 4, 3};
    logic [31:0] bp_pc;

    initial begin
        model_clear();
        resetn               = 1'b0;
        bus.i_lookup_valid   = 1'b0;
        bus.i_lookup_pc      = '0;
        bus.i_bco_valid      = 1'b0;
        bus.i_bco_pc         = '0;
        bus.i_bco_oldpattern = '0;
        bus.i_bco_taken      = 1'b0;
        bus.i_bco_target     = '0;
        repeat (2) @(negedge clk);
        chk_outputs_clear("rst");
        chk_eq("rst_ready", bus.o_lookup_ready, 1);
        resetn = 1'b1;

        // Cold lookup misses.
        lookup(32'h0000_1000);
        idle();

        // Install 0x1000; count shows 1 then drains to 0.
        bco(32'h0000_1000, 2'b01, 1'b1, 32'h0000_2000);
        idle();
        chk_eq("cnt_after_push", bus.o_fifo_count, 1);
        idle();
        chk_eq("cnt_after_drain", bus.o_fifo_count, 0);
        lookup(32'h0000_1000);
        idle();

        // Saturation at both ends; not-taken keeps target.
        bco(32'h0000_1004, 2'b11, 1'b1, 32'h0000_4000);
        idle(); idle();
        lookup(32'h0000_1004);
        bco(32'h0000_1004, 2'b00, 1'b0, 32'h0000_5555);
        idle(); idle();
        lookup(32'h0000_1004);
        idle();

        // Aliasing on index 0.
        lookup(32'h0000_1040);
        bco(32'h0000_1040, 2'b01, 1'b1, 32'h0000_3000);
        idle(); idle();
        lookup(32'h0000_1000);
        lookup(32'h0000_1040);
        idle();

        // Back-pressure: continuous lookups with a burst of five reports.
        for (int k = 0; k < 7; k++) begin
            bp_pc = 32'h0000_1014 + 32'(4 * k);
            if (k < 5) drive(1'b1, 32'h0000_2000, 1'b1, bp_pc, 2'(k % 4), k[0], 32'h0000_7000 + 32'(k));
            else       lookup(32'h0000_2000);
            chk_eq("bp_count", bus.o_fifo_count, exp_cnt[k]);
            chk_eq("bp_ready", bus.o_lookup_ready, (exp_cnt[k] != 4) ? 1 : 0);
        end
        repeat (4) idle();
        chk_eq("bp_drained", bus.o_fifo_count, 0);
        for (int k = 0; k < 5; k++) lookup(32'h0000_1014 + 32'(4 * k));
        idle();

        // Async reset with pending updates and a lookup in flight.
        drive(1'b1, 32'h0000_2000, 1'b1, 32'h0000_1028, 2'b01, 1'b1, 32'h0000_6000);
        drive(1'b1, 32'h0000_2000, 1'b1, 32'h0000_102C, 2'b01, 1'b1, 32'h0000_6004);
        drive(1'b1, 32'h0000_2000, 1'b1, 32'h0000_1030, 2'b01, 1'b1, 32'h0000_6008);
        lookup(32'h0000_2000);
        chk_eq("pre_rst_count", bus.o_fifo_count, 3);
        #2;
        resetn               = 1'b0;
        bus.i_lookup_valid   = 1'b0;
        bus.i_bco_valid      = 1'b0;
        #1;
        chk_outputs_clear("arst");
        sb.delete();
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
        lookup(32'h0000_1000);
        lookup(32'h0000_1040);
        lookup(32'h0000_1014);
        lookup(32'h0000_1028);
        repeat (3) idle();
        chk_eq("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
